// File: rtl/apb_multi_fifo_if.sv
// ---------------------------------------------------------------------------
// apb_multi_fifo_if
//   APB3/APB4 bus bundle for the apb_multi_fifo peripheral.
//
//   Signals (master view):
//     PADDR   [31:0]  byte address, bit 31 selects data space
//     PPROT   [2:0]   protection attributes (carried, not interpreted)
//     PSEL            slave select
//     PENABLE         access phase
//     PWRITE          1 = write, 0 = read
//     PWDATA  [31:0]  write data
//     PSTRB   [3:0]   byte strobes
//     PREADY          slave ready (always 1 from this slave)
//     PRDATA  [31:0]  read data
//     PSLVERR         error response
// ---------------------------------------------------------------------------
interface apb_multi_fifo_if;
   logic [31:0] PADDR;
   logic [2:0]  PPROT;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [3:0]  PSTRB;
   logic        PREADY;
   logic [31:0] PRDATA;
   logic        PSLVERR;

   modport master (
      output PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
      input  PREADY, PRDATA, PSLVERR
   );

   modport slave (
      input  PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
      output PREADY, PRDATA, PSLVERR
   );
endinterface

// File: rtl/apb_multi_fifo.sv
// ---------------------------------------------------------------------------
// apb_multi_fifo
//   Bank of NUM_CH independent synchronous FIFOs behind one APB slave.
//   Each channel has a runtime depth (8 << DEPTH_CODE, clamped to
//   MAX_DEPTH), an almost-full threshold, sticky overflow/underflow flags
//   and a flush control. A maskable level interrupt summarises status.
//
//   Ports:
//     PCLK         clock, all state on the rising edge
//     PRESET       asynchronous active-high reset
//     bus          APB slave (apb_multi_fifo_if.slave), zero wait states
//     full         per-channel full status
//     empty        per-channel empty status
//     almost_full  per-channel THRESH != 0 && count >= THRESH
//     irq          OR of enabled (almost_full | OVF | UDF)
//
//   Map: channel c registers at 0x10*c (CFG, THRESH, STATUS, reserved),
//   IRQ_EN at 0x80, data space at PADDR[31]=1 with channel in PADDR[4:2].
// ---------------------------------------------------------------------------
module apb_multi_fifo #(
   parameter int WIDTH     = 8,
   parameter int MAX_DEPTH = 256,
   parameter int NUM_CH    = 4
) (
   input  logic              PCLK,
   input  logic              PRESET,
   apb_multi_fifo_if.slave   bus,
   output logic [NUM_CH-1:0] full,
   output logic [NUM_CH-1:0] empty,
   output logic [NUM_CH-1:0] almost_full,
   output logic              irq
);

   localparam int LOG      = $clog2(MAX_DEPTH);
   localparam int CW       = LOG + 1;
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int MAX_CODE = LOG - 3;

   typedef enum logic [1:0] {
      REG_CFG    = 2'd0,
      REG_THRESH = 2'd1,
      REG_STATUS = 2'd2,
      REG_RSVD   = 2'd3
   } reg_sel_e;

   // Depth selected by a code; codes past the storage size clamp to it.
   function automatic logic [CW-1:0] depth_of(input logic [2:0] code);
      logic [2:0] eff;
      eff = (int'(code) > MAX_CODE) ? 3'(MAX_CODE) : code;
      return CW'(8) << eff;
   endfunction

   // Pointers wrap at the channel's current depth, not at MAX_DEPTH.
   function automatic logic [LOG-1:0] next_ptr(input logic [LOG-1:0] p,
                                                input logic [LOG-1:0] last);
      return (p == last) ? '0 : p + LOG'(1);
   endfunction

   // ---------------- channel state ----------------
   logic [WIDTH-1:0] mem [NUM_CH][MAX_DEPTH];
   logic [LOG-1:0]   w_ptr [NUM_CH];
   logic [LOG-1:0]   r_ptr [NUM_CH];
   logic [CW-1:0]    count [NUM_CH];
   logic [2:0]       depth_code [NUM_CH];
   logic [CW-1:0]    thresh [NUM_CH];
   logic [NUM_CH-1:0] ovf;
   logic [NUM_CH-1:0] udf;
   logic [NUM_CH-1:0] irq_en;

   logic [CW-1:0]    depth [NUM_CH];
   logic [LOG-1:0]   last  [NUM_CH];

   // ---------------- decode ----------------
   logic            access;
   logic            is_data;
   logic            is_irq_en;
   logic            reg_valid;
   logic            data_valid;
   logic [CH_W-1:0] rch;
   logic [CH_W-1:0] dch;
   reg_sel_e        rsel;
   logic            push_req;
   logic            pop_req;
   logic            push_ok;
   logic            pop_ok;
   logic            reg_wr;
   logic            irq_wr;
   logic [31:0]     wmask;
   logic [31:0]     rdata;

   assign access     = bus.PSEL & bus.PENABLE;
   assign is_data    = bus.PADDR[31];
   assign is_irq_en  = (bus.PADDR[30:0] == 31'h80);
   assign reg_valid  = !is_data &&
                       ((bus.PADDR[30:0] < 31'(16 * NUM_CH)) || is_irq_en);
   assign data_valid = is_data && (bus.PADDR[30:5] == '0) &&
                       (int'(bus.PADDR[4:2]) < NUM_CH);
   assign rch        = bus.PADDR[4+CH_W-1:4];
   assign dch        = bus.PADDR[2+CH_W-1:2];
   assign rsel       = reg_sel_e'(bus.PADDR[3:2]);

   assign push_req = access &  bus.PWRITE & data_valid;
   assign pop_req  = access & !bus.PWRITE & data_valid;
   assign push_ok  = push_req & !full[dch];
   assign pop_ok   = pop_req  & !empty[dch];
   assign reg_wr   = access & bus.PWRITE & reg_valid & !is_irq_en;
   assign irq_wr   = access & bus.PWRITE & reg_valid &  is_irq_en;

   assign wmask = {{8{bus.PSTRB[3]}}, {8{bus.PSTRB[2]}},
                   {8{bus.PSTRB[1]}}, {8{bus.PSTRB[0]}}};

   // PPROT carries no meaning for this slave.
   logic unused_ok;
   assign unused_ok = &{1'b0, bus.PPROT};

   // ---------------- per-channel status ----------------
   always_comb begin
      full        = '0;
      empty       = '0;
      almost_full = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         depth[c]       = depth_of(depth_code[c]);
         last[c]        = LOG'(depth[c] - CW'(1));
         full[c]        = (count[c] == depth[c]);
         empty[c]       = (count[c] == '0);
         almost_full[c] = (thresh[c] != '0) && (count[c] >= thresh[c]);
      end
   end

   always_comb begin
      irq = 1'b0;
      for (int c = 0; c < NUM_CH; c++)
         irq = irq | (irq_en[c] & (almost_full[c] | ovf[c] | udf[c]));
   end

   // ---------------- APB response ----------------
   assign bus.PREADY  = 1'b1;
   assign bus.PSLVERR = access & (!(reg_valid | data_valid) |
                                  (push_req & full[dch]) |
                                  (pop_req  & empty[dch]));

   // NOTE: rdata gets a default before any branch so every path assigns it;
   // a missing default here would infer a latch.
   always_comb begin
      rdata = '0;
      if (access && !bus.PWRITE) begin
         if (data_valid) begin
            if (!empty[dch])
               rdata = 32'(mem[dch][r_ptr[dch]]);
         end else if (reg_valid) begin
            if (is_irq_en) begin
               rdata = 32'(irq_en);
            end else begin
               case (rsel)
                  REG_CFG:    rdata = {29'b0, depth_code[rch]};
                  REG_THRESH: rdata = 32'(thresh[rch]);
                  REG_STATUS: rdata = {12'b0, udf[rch], ovf[rch], full[rch],
                                       empty[rch], 16'(count[rch])};
                  default:    rdata = '0;
               endcase
            end
         end
      end
   end
   assign bus.PRDATA = rdata;

   // ---------------- state update ----------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of code order.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         w_ptr      <= '{default: '0};
         r_ptr      <= '{default: '0};
         count      <= '{default: '0};
         depth_code <= '{default: '0};
         thresh     <= '{default: '0};
         ovf        <= '0;
         udf        <= '0;
         irq_en     <= '0;
      end else begin
         // Register writes come first so a same-cycle OVF/UDF set below
         // overrides a W1C clear.
         if (reg_wr) begin
            case (rsel)
               REG_CFG: begin
                  if (bus.PSTRB[0] && count[rch] == '0)
                     depth_code[rch] <= bus.PWDATA[2:0];
                  if (bus.PSTRB[1] && bus.PWDATA[8]) begin
                     w_ptr[rch] <= '0;
                     r_ptr[rch] <= '0;
                     count[rch] <= '0;
                  end
               end
               REG_THRESH:
                  thresh[rch] <= CW'((32'(thresh[rch]) & ~wmask) |
                                     (bus.PWDATA & wmask));
               REG_STATUS: begin
                  if (bus.PSTRB[2] && bus.PWDATA[18]) ovf[rch] <= 1'b0;
                  if (bus.PSTRB[2] && bus.PWDATA[19]) udf[rch] <= 1'b0;
               end
               default: ;
            endcase
         end

         if (irq_wr)
            irq_en <= NUM_CH'((32'(irq_en) & ~wmask) | (bus.PWDATA & wmask));

         if (push_ok) begin
            w_ptr[dch] <= next_ptr(w_ptr[dch], last[dch]);
            count[dch] <= count[dch] + CW'(1);
         end
         if (pop_ok) begin
            r_ptr[dch] <= next_ptr(r_ptr[dch], last[dch]);
            count[dch] <= count[dch] - CW'(1);
         end
         if (push_req && full[dch])  ovf[dch] <= 1'b1;
         if (pop_req  && empty[dch]) udf[dch] <= 1'b1;
      end
   end

   // NOTE: the storage array has no reset; its contents are only visible
   // through count-qualified reads, and leaving it unreset lets it map to RAM.
   always_ff @(posedge PCLK) begin
      if (push_ok)
         mem[dch][w_ptr[dch]] <= bus.PWDATA[WIDTH-1:0];
   end

endmodule

// File: tb/tb_apb_multi_fifo.sv
// ---------------------------------------------------------------------------
// tb_apb_multi_fifo
//   Directed self-checking bench for apb_multi_fifo (defaults: WIDTH=8,
//   MAX_DEPTH=256, NUM_CH=4). One task per scenario, each with its own
//   inline comparisons against hand-computed values.
// ---------------------------------------------------------------------------
module tb_apb_multi_fifo;

   logic       PCLK;
   logic       PRESET;
   logic [3:0] full;
   logic [3:0] empty;
   logic [3:0] almost_full;
   logic       irq;

   apb_multi_fifo_if bus();

   apb_multi_fifo #(.WIDTH(8), .MAX_DEPTH(256), .NUM_CH(4)) dut (
      .PCLK        (PCLK),
      .PRESET      (PRESET),
      .bus         (bus),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .irq         (irq)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   int checks   = 0;
   int failures = 0;

   logic [31:0] rd;
   logic        er;

   // One full APB transfer: setup, access (sampled on the falling edge),
   // then return 1 time unit after the completing rising edge.
   task automatic apb_xfer(input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           output logic [31:0] rdata, output logic err);
      @(posedge PCLK); #1;
      bus.PSEL    = 1'b1;
      bus.PENABLE = 1'b0;
      bus.PWRITE  = wr;
      bus.PADDR   = addr;
      bus.PWDATA  = wdata;
      bus.PSTRB   = strb;
      @(posedge PCLK); #1;
      bus.PENABLE = 1'b1;
      @(negedge PCLK);
      rdata = bus.PRDATA;
      err   = bus.PSLVERR;
      @(posedge PCLK); #1;
      bus.PSEL    = 1'b0;
      bus.PENABLE = 1'b0;
   endtask

   task automatic wr32(input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb);
      logic [31:0] d;
      apb_xfer(1'b1, addr, data, strb, d, er);
   endtask

   task automatic rd32(input logic [31:0] addr);
      apb_xfer(1'b0, addr, 32'h0, 4'h0, rd, er);
   endtask

   // -------------------------------------------------------------------
   task automatic test_reset;
      PRESET = 1'b1;
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      checks++; if (empty !== 4'hF) begin failures++; $display("FAIL reset_empty got=%h exp=%h", empty, 4'hF); end
      checks++; if (full !== 4'h0) begin failures++; $display("FAIL reset_full got=%h exp=%h", full, 4'h0); end
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
      checks++; if (bus.PREADY !== 1'b1) begin failures++; $display("FAIL reset_pready got=%b exp=1", bus.PREADY); end
      checks++; if (bus.PRDATA !== 32'h0) begin failures++; $display("FAIL reset_prdata got=%h exp=0", bus.PRDATA); end
      checks++; if (bus.PSLVERR !== 1'b0) begin failures++; $display("FAIL reset_pslverr got=%b exp=0", bus.PSLVERR); end
      PRESET = 1'b0;
      rd32(32'h08);
      checks++; if (rd !== 32'h0001_0000) begin failures++; $display("FAIL reset_status0 got=%h exp=%h", rd, 32'h0001_0000); end
      rd32(32'h80);
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_irq_en got=%h exp=0", rd); end
      rd32(32'h00);
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_cfg0 got=%h exp=0", rd); end
   endtask

   // -------------------------------------------------------------------
   task automatic test_depth8;
      for (int i = 0; i < 8; i++) begin
         wr32(32'h8000_0004, 32'h11 + i, 4'hF);
         checks++; if (er !== 1'b0) begin failures++; $display("FAIL d8_push_err i=%0d got=%b exp=0", i, er); end
      end
      checks++; if (full[1] !== 1'b1) begin failures++; $display("FAIL d8_full got=%b exp=1", full[1]); end
      rd32(32'h18);
      checks++; if (rd !== 32'h0002_0008) begin failures++; $display("FAIL d8_status_full got=%h exp=%h", rd, 32'h0002_0008); end
      wr32(32'h8000_0004, 32'h99, 4'hF);
      checks++; if (er !== 1'b1) begin failures++; $display("FAIL d8_ovf_err got=%b exp=1", er); end
      rd32(32'h18);
      checks++; if (rd !== 32'h0006_0008) begin failures++; $display("FAIL d8_status_ovf got=%h exp=%h", rd, 32'h0006_0008); end
      for (int i = 0; i < 8; i++) begin
         rd32(32'h8000_0004);
         checks++; if (rd !== 32'h11 + i || er !== 1'b0) begin failures++; $display("FAIL d8_pop i=%0d got=%h err=%b exp=%h err=0", i, rd, er, 32'h11 + i); end
      end
      rd32(32'h8000_0004);
      checks++; if (rd !== 32'h0 || er !== 1'b1) begin failures++; $display("FAIL d8_udf_pop got=%h err=%b exp=0 err=1", rd, er); end
      rd32(32'h18);
      checks++; if (rd !== 32'h000D_0000) begin failures++; $display("FAIL d8_status_udf got=%h exp=%h", rd, 32'h000D_0000); end
      wr32(32'h18, 32'h000C_0000, 4'b0100);
      rd32(32'h18);
      checks++; if (rd !== 32'h0001_0000) begin failures++; $display("FAIL d8_w1c got=%h exp=%h", rd, 32'h0001_0000); end
   endtask

   // -------------------------------------------------------------------
   task automatic test_wrap;
      wr32(32'h00, 32'h3, 4'b0001);
      rd32(32'h00);
      checks++; if (rd !== 32'h3) begin failures++; $display("FAIL wrap_cfg got=%h exp=3", rd); end
      for (int i = 0; i < 30; i++) wr32(32'h8000_0000, 32'(i), 4'hF);
      rd32(32'h08);
      checks++; if (rd !== 32'd30) begin failures++; $display("FAIL wrap_count30 got=%h exp=%h", rd, 32'd30); end
      for (int i = 30; i < 200; i++) begin
         wr32(32'h8000_0000, 32'(i), 4'hF);
         rd32(32'h8000_0000);
         checks++; if (rd !== 32'(i - 30)) begin failures++; $display("FAIL wrap_pop i=%0d got=%h exp=%h", i, rd, 32'(i - 30)); end
      end
      for (int i = 170; i < 200; i++) begin
         rd32(32'h8000_0000);
         checks++; if (rd !== 32'(i)) begin failures++; $display("FAIL wrap_drain i=%0d got=%h exp=%h", i, rd, 32'(i)); end
      end
      checks++; if (empty[0] !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%b exp=1", empty[0]); end
      // Fill to exactly 64 to show the selected depth is in force.
      for (int i = 0; i < 63; i++) wr32(32'h8000_0000, 32'(i), 4'hF);
      checks++; if (full[0] !== 1'b0) begin failures++; $display("FAIL wrap_not_full63 got=%b exp=0", full[0]); end
      wr32(32'h8000_0000, 32'hEE, 4'hF);
      checks++; if (full[0] !== 1'b1 || er !== 1'b0) begin failures++; $display("FAIL wrap_full64 got=%b err=%b exp=1 err=0", full[0], er); end
      wr32(32'h8000_0000, 32'hEF, 4'hF);
      checks++; if (er !== 1'b1) begin failures++; $display("FAIL wrap_ovf65 got=%b exp=1", er); end
      wr32(32'h00, 32'h0, 4'b0001);
      rd32(32'h00);
      checks++; if (rd !== 32'h3) begin failures++; $display("FAIL wrap_cfg_locked got=%h exp=3", rd); end
      wr32(32'h00, 32'h100, 4'b0010);
      wr32(32'h08, 32'h000C_0000, 4'b0100);
      rd32(32'h08);
      checks++; if (rd !== 32'h0001_0000) begin failures++; $display("FAIL wrap_cleanup got=%h exp=%h", rd, 32'h0001_0000); end
   endtask

   // -------------------------------------------------------------------
   task automatic test_thresh_irq;
      wr32(32'h24, 32'h4, 4'b0011);
      wr32(32'h24, 32'h7, 4'b0000);
      rd32(32'h24);
      checks++; if (rd !== 32'h4) begin failures++; $display("FAIL th_readback got=%h exp=4", rd); end
      wr32(32'h80, 32'h4, 4'b0001);
      for (int i = 0; i < 3; i++) wr32(32'h8000_0008, 32'h20 + i, 4'hF);
      checks++; if (irq !== 1'b0 || almost_full !== 4'h0) begin failures++; $display("FAIL th_below got irq=%b af=%h exp irq=0 af=0", irq, almost_full); end
      wr32(32'h8000_0008, 32'h23, 4'hF);
      checks++; if (irq !== 1'b1 || almost_full !== 4'b0100) begin failures++; $display("FAIL th_reached got irq=%b af=%h exp irq=1 af=4", irq, almost_full); end
      rd32(32'h8000_0008);
      checks++; if (rd !== 32'h20) begin failures++; $display("FAIL th_pop got=%h exp=20", rd); end
      checks++; if (irq !== 1'b0 || almost_full !== 4'h0) begin failures++; $display("FAIL th_after_pop got irq=%b af=%h exp irq=0 af=0", irq, almost_full); end
      for (int i = 0; i < 3; i++) rd32(32'h8000_0008);
      wr32(32'h80, 32'h0, 4'b0001);
   endtask

   // -------------------------------------------------------------------
   task automatic test_flush;
      for (int i = 0; i < 5; i++) wr32(32'h8000_000C, 32'h30 + i, 4'hF);
      rd32(32'h38);
      checks++; if (rd !== 32'h0000_0005) begin failures++; $display("FAIL fl_count5 got=%h exp=5", rd); end
      wr32(32'h30, 32'h100, 4'b0010);
      checks++; if (empty[3] !== 1'b1) begin failures++; $display("FAIL fl_empty got=%b exp=1", empty[3]); end
      rd32(32'h38);
      checks++; if (rd !== 32'h0001_0000) begin failures++; $display("FAIL fl_status got=%h exp=%h", rd, 32'h0001_0000); end
      rd32(32'h30);
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL fl_cfg_read got=%h exp=0", rd); end
      wr32(32'h8000_000C, 32'hA5, 4'hF);
      rd32(32'h8000_000C);
      checks++; if (rd !== 32'hA5) begin failures++; $display("FAIL fl_new_data got=%h exp=a5", rd); end
      rd32(32'h8000_000C);
      checks++; if (rd !== 32'h0 || er !== 1'b1) begin failures++; $display("FAIL fl_udf got=%h err=%b exp=0 err=1", rd, er); end
      for (int i = 0; i < 9; i++) wr32(32'h8000_000C, 32'h40 + i, 4'hF);
      rd32(32'h38);
      checks++; if (rd !== 32'h000E_0008) begin failures++; $display("FAIL fl_full_flags got=%h exp=%h", rd, 32'h000E_0008); end
      wr32(32'h30, 32'h100, 4'b0010);
      rd32(32'h38);
      checks++; if (rd !== 32'h000D_0000) begin failures++; $display("FAIL fl_sticky_kept got=%h exp=%h", rd, 32'h000D_0000); end
      wr32(32'h38, 32'h000C_0000, 4'b1011);
      rd32(32'h38);
      checks++; if (rd !== 32'h000D_0000) begin failures++; $display("FAIL fl_w1c_nostrb got=%h exp=%h", rd, 32'h000D_0000); end
      wr32(32'h38, 32'h000C_0000, 4'b0100);
      rd32(32'h38);
      checks++; if (rd !== 32'h0001_0000) begin failures++; $display("FAIL fl_w1c got=%h exp=%h", rd, 32'h0001_0000); end
   endtask

   // -------------------------------------------------------------------
   task automatic test_invalid;
      rd32(32'h8000_0020);
      checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL inv_data_ch4_rd got=%h err=%b exp=0 err=1", rd, er); end
      wr32(32'h8000_0020, 32'h55, 4'hF);
      checks++; if (er !== 1'b1) begin failures++; $display("FAIL inv_data_ch4_wr got=%b exp=1", er); end
      wr32(32'h8000_0100, 32'h56, 4'hF);
      checks++; if (er !== 1'b1) begin failures++; $display("FAIL inv_data_hi got=%b exp=1", er); end
      rd32(32'h90);
      checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL inv_0x90_rd got=%h err=%b exp=0 err=1", rd, er); end
      wr32(32'h90, 32'hFF, 4'hF);
      checks++; if (er !== 1'b1) begin failures++; $display("FAIL inv_0x90_wr got=%b exp=1", er); end
      wr32(32'h40, 32'h7, 4'hF);
      checks++; if (er !== 1'b1) begin failures++; $display("FAIL inv_0x40_wr got=%b exp=1", er); end
      rd32(32'h0C);
      checks++; if (er !== 1'b0 || rd !== 32'h0) begin failures++; $display("FAIL rsvd_rd got=%h err=%b exp=0 err=0", rd, er); end
      checks++; if (empty !== 4'hF || irq !== 1'b0) begin failures++; $display("FAIL inv_no_change got empty=%h irq=%b exp empty=f irq=0", empty, irq); end
      rd32(32'h80);
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL inv_irq_en got=%h exp=0", rd); end
   endtask

   // -------------------------------------------------------------------
   task automatic test_interleave;
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 4; c++)
            wr32(32'h8000_0000 | (32'(c) << 2), (r == 0 ? 32'hC0 : 32'hD0) + 32'(c), 4'hF);
      for (int c = 0; c < 4; c++) begin
         rd32(32'h08 + 32'(c) * 32'h10);
         checks++; if (rd !== 32'h2) begin failures++; $display("FAIL il_count ch=%0d got=%h exp=2", c, rd); end
      end
      for (int c = 3; c >= 0; c--) begin
         rd32(32'h8000_0000 | (32'(c) << 2));
         checks++; if (rd !== 32'hC0 + 32'(c)) begin failures++; $display("FAIL il_pop1 ch=%0d got=%h exp=%h", c, rd, 32'hC0 + 32'(c)); end
         rd32(32'h8000_0000 | (32'(c) << 2));
         checks++; if (rd !== 32'hD0 + 32'(c)) begin failures++; $display("FAIL il_pop2 ch=%0d got=%h exp=%h", c, rd, 32'hD0 + 32'(c)); end
      end
   endtask

   // -------------------------------------------------------------------
   task automatic test_reset_mid;
      wr32(32'h8000_0004, 32'h61, 4'hF);
      // Push to ch1 interrupted by reset during its access phase.
      @(posedge PCLK); #1;
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
      bus.PADDR = 32'h8000_0004; bus.PWDATA = 32'h62; bus.PSTRB = 4'hF;
      @(posedge PCLK); #1;
      bus.PENABLE = 1'b1;
      @(negedge PCLK);
      PRESET = 1'b1;
      @(posedge PCLK); #1;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
      @(negedge PCLK);
      PRESET = 1'b0;
      checks++; if (empty !== 4'hF) begin failures++; $display("FAIL rst_mid_empty got=%h exp=f", empty); end
      rd32(32'h18);
      checks++; if (rd !== 32'h0001_0000) begin failures++; $display("FAIL rst_mid_status1 got=%h exp=%h", rd, 32'h0001_0000); end
      rd32(32'h00);
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rst_mid_cfg0 got=%h exp=0", rd); end
   endtask

   // -------------------------------------------------------------------
   initial begin
      PRESET      = 1'b1;
      bus.PSEL    = 1'b0;
      bus.PENABLE = 1'b0;
      bus.PWRITE  = 1'b0;
      bus.PADDR   = '0;
      bus.PWDATA  = '0;
      bus.PSTRB   = '0;
      bus.PPROT   = '0;
      test_reset();
      test_depth8();
      test_wrap();
      test_thresh_irq();
      test_flush();
      test_invalid();
      test_interleave();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
